priority_mux_scheduler: RTL and testbench

Front-end controller for `priority_mux`. It buffers one pending item per requester and computes an aged effective priority for each. It drives the mux request/priority/signal buses, waits for the one-hot acknowledge, and returns the winning item on a valid/ready output. Ageing stops low-priority requesters from starving behind a steady stream of higher-priority traffic.

---
 rtl/priority_sched_pkg.sv | 37 +++
 rtl/priority_age_slot.sv | 51 +++++
 rtl/priority_mux_scheduler.sv | 178 +++++++++++++++++
 tb/tb_priority_mux_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/priority_sched_pkg.sv
// priority_sched_pkg: shared types and helpers for priority_mux_scheduler.
//   sched_state_t  - scheduler FSM states
//   eff_priority   - aged priority: base - (age >> shift), floored at 0
//   is_onehot      - true when exactly one bit is set
//   onehot_encode  - index of the set bit of a one-hot vector
// The helpers work on 32-bit values, so callers zero-extend their operands
// and truncate the result. This supports at most 32 requesters.
package priority_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    OUTPUT = 2'd2
  } sched_state_t;

  function automatic logic [31:0] eff_priority(input logic [31:0] base,
                                               input logic [31:0] age,
                                               input logic [31:0] shift);
    logic [31:0] boost;
    boost = age >> shift;
    return (boost >= base) ? 32'd0 : (base - boost);
  endfunction

  function automatic logic is_onehot(input logic [31:0] vec);
    return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
  endfunction

  function automatic logic [31:0] onehot_encode(input logic [31:0] vec);
    logic [31:0] idx;
    idx = 32'd0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = 32'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/priority_age_slot.sv
// priority_age_slot: one pending item for one requester.
//   clk, rst        - clock, synchronous active-high reset
//   load            - capture load_priority/load_data, mark valid, clear age
//   grant           - item won arbitration: invalidate, clear age
//   age_inc         - item lost a round: saturating age increment
//   valid/data/base/age - stored state
module priority_age_slot
  import priority_sched_pkg::*;
#(
  parameter int unsigned PRIORITY_WIDTH = 2,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned AGE_WIDTH      = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [PRIORITY_WIDTH-1:0] load_priority,
  input  logic [DATA_WIDTH-1:0]     load_data,
  input  logic                      grant,
  input  logic                      age_inc,
  output logic                      valid,
  output logic [DATA_WIDTH-1:0]     data,
  output logic [PRIORITY_WIDTH-1:0] base,
  output logic [AGE_WIDTH-1:0]      age
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      base  <= '0;
      age   <= '0;
    end else begin
      if (grant) begin
        valid <= 1'b0;
        age   <= '0;
      end else if (age_inc && (age != '1)) begin
        age <= age + AGE_WIDTH'(1);
      end
      // A load only happens into an empty slot, and grant/age_inc only touch
      // slots that are full, so a load never collides with them.
      if (load) begin
        valid <= 1'b1;
        data  <= load_data;
        base  <= load_priority;
        age   <= '0;
      end
    end
  end

endmodule

// File: rtl/priority_mux_scheduler.sv
// priority_mux_scheduler: front-end controller for priority_mux.
// Buffers one item per requester, presents a frozen snapshot of aged
// priorities and payloads to the mux, waits for the one-hot acknowledge and
// returns the winner on a valid/ready output.
//   clk, rst                       - clock, synchronous active-high reset
//   req_valid/req_priority/req_data - per-requester offer (requester i at low slice)
//   req_ready                      - slot i empty
//   mux_req/mux_priorities/mux_signals - registered drive to the mux
//   mux_ack/mux_signal/mux_busy    - mux response
//   out_valid/out_data/out_index/out_ready - granted item handshake
//   err                            - one-cycle pulse on ack timeout or bad ack
//
//   state  | meaning
//   IDLE   | wait for a valid slot and an idle mux, then snapshot and issue
//   ISSUE  | mux_req driven from issue_mask, waiting for ack or timeout
//   OUTPUT | winner held on out_*, waiting for out_ready
module priority_mux_scheduler
  import priority_sched_pkg::*;
#(
  parameter int unsigned N_PRIORITY_WIDTH = 2,
  parameter int unsigned N_SIGNAL_WIDTH   = 8,
  parameter int unsigned N_SIGNALS        = 4,
  parameter int unsigned AGE_WIDTH        = 3,
  parameter int unsigned AGE_SHIFT        = 1,
  parameter int unsigned ACK_TIMEOUT      = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_SIGNALS-1:0]                   req_valid,
  input  logic [N_PRIORITY_WIDTH*N_SIGNALS-1:0]  req_priority,
  input  logic [N_SIGNAL_WIDTH*N_SIGNALS-1:0]    req_data,
  output logic [N_SIGNALS-1:0]                   req_ready,
  output logic [N_SIGNALS-1:0]                   mux_req,
  output logic [N_PRIORITY_WIDTH*N_SIGNALS-1:0]  mux_priorities,
  output logic [N_SIGNAL_WIDTH*N_SIGNALS-1:0]    mux_signals,
  input  logic [N_SIGNALS-1:0]                   mux_ack,
  input  logic [N_SIGNAL_WIDTH-1:0]              mux_signal,
  input  logic                                   mux_busy,
  output logic                                   out_valid,
  output logic [N_SIGNAL_WIDTH-1:0]              out_data,
  output logic [$clog2(N_SIGNALS)-1:0]           out_index,
  input  logic                                   out_ready,
  output logic                                   err
);

  localparam int unsigned PW = N_PRIORITY_WIDTH;
  localparam int unsigned DW = N_SIGNAL_WIDTH;
  localparam int unsigned IW = $clog2(N_SIGNALS);
  localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  sched_state_t state, state_next;

  logic [N_SIGNALS-1:0]    slot_valid;
  logic [N_SIGNALS-1:0]    slot_load;
  logic [N_SIGNALS-1:0]    slot_grant;
  logic [N_SIGNALS-1:0]    slot_age_inc;
  logic [DW-1:0]           slot_data [N_SIGNALS];
  logic [PW-1:0]           slot_base [N_SIGNALS];
  logic [AGE_WIDTH-1:0]    slot_age  [N_SIGNALS];

  logic [PW*N_SIGNALS-1:0] eff_packed;
  logic [DW*N_SIGNALS-1:0] data_packed;
  logic [N_SIGNALS-1:0]    issue_mask;
  logic [TW-1:0]           timer;

  logic                    enter_issue;
  logic                    ack_good;
  logic                    abort;

  assign req_ready = ~slot_valid;
  assign slot_load = req_valid & ~slot_valid;
  assign out_valid = (state == OUTPUT);

  for (genvar i = 0; i < N_SIGNALS; i++) begin : g_slot
    priority_age_slot #(
      .PRIORITY_WIDTH (PW),
      .DATA_WIDTH     (DW),
      .AGE_WIDTH      (AGE_WIDTH)
    ) u_slot (
      .clk           (clk),
      .rst           (rst),
      .load          (slot_load[i]),
      .load_priority (req_priority[i*PW +: PW]),
      .load_data     (req_data[i*DW +: DW]),
      .grant         (slot_grant[i]),
      .age_inc       (slot_age_inc[i]),
      .valid         (slot_valid[i]),
      .data          (slot_data[i]),
      .base          (slot_base[i]),
      .age           (slot_age[i])
    );
  end

  always_comb begin
    eff_packed  = '0;
    data_packed = '0;
    for (int i = 0; i < N_SIGNALS; i++) begin
      eff_packed[i*PW +: PW]  = PW'(eff_priority(32'(slot_base[i]), 32'(slot_age[i]),
                                                 32'(AGE_SHIFT)));
      data_packed[i*DW +: DW] = slot_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    enter_issue  = 1'b0;
    ack_good     = 1'b0;
    abort        = 1'b0;
    slot_grant   = '0;
    slot_age_inc = '0;
    case (state)
      IDLE: begin
        if ((|slot_valid) && !mux_busy) begin
          state_next  = ISSUE;
          enter_issue = 1'b1;
        end
      end
      ISSUE: begin
        // An ack in the last timer cycle still wins over the timeout.
        if (|mux_ack) begin
          if (is_onehot(32'(mux_ack)) && ((mux_ack & ~issue_mask) == '0)) begin
            ack_good     = 1'b1;
            slot_grant   = mux_ack;
            slot_age_inc = issue_mask & ~mux_ack;
            state_next   = OUTPUT;
          end else begin
            abort      = 1'b1;
            state_next = IDLE;
          end
        end else if (timer == '0) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      OUTPUT: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Snapshot, request drive and timeout down-counter. The counter is loaded
  // with ACK_TIMEOUT-1 on ISSUE entry, so ISSUE lasts at most ACK_TIMEOUT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      issue_mask     <= '0;
      mux_req        <= '0;
      mux_priorities <= '1;
      mux_signals    <= '0;
      timer          <= '0;
      out_data       <= '0;
      out_index      <= '0;
      err            <= 1'b0;
    end else begin
      err <= abort;
      if (enter_issue) begin
        issue_mask     <= slot_valid;
        mux_req        <= slot_valid;
        mux_priorities <= eff_packed;
        mux_signals    <= data_packed;
        timer          <= TW'(ACK_TIMEOUT - 1);
      end else if (state == ISSUE) begin
        if (state_next != ISSUE) mux_req <= '0;
        else                     timer   <= timer - TW'(1);
      end
      if (ack_good) begin
        out_data  <= mux_signal;
        out_index <= IW'(onehot_encode(32'(mux_ack)));
      end
    end
  end

endmodule

// File: tb/tb_priority_mux_scheduler.sv
module tb_priority_mux_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [7:0]  req_priority;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  mux_req;
  logic [7:0]  mux_priorities;
  logic [31:0] mux_signals;
  logic [3:0]  mux_ack;
  logic [7:0]  mux_signal;
  logic        mux_busy;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_index;
  logic        out_ready;
  logic        err;

  int checks   = 0;
  int failures = 0;

  priority_mux_scheduler #(
    .N_PRIORITY_WIDTH (2),
    .N_SIGNAL_WIDTH   (8),
    .N_SIGNALS        (4),
    .AGE_WIDTH        (3),
    .AGE_SHIFT        (1),
    .ACK_TIMEOUT      (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_priority   (req_priority),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .mux_req        (mux_req),
    .mux_priorities (mux_priorities),
    .mux_signals    (mux_signals),
    .mux_ack        (mux_ack),
    .mux_signal     (mux_signal),
    .mux_busy       (mux_busy),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_index      (out_index),
    .out_ready      (out_ready),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_issue(input int budget);
    int n;
    n = 0;
    while ((mux_req == 4'b0000) && (n < budget)) begin
      tick();
      n++;
    end
    chk("issue_wait", 64'(mux_req != 4'b0000), 64'd1);
  endtask

  // One arbitration round: the bench plays the mux (lowest value wins, lower
  // index on a tie), slot 0 is reloaded whenever it wins.
  task automatic round(input int loser, input logic [1:0] exp_eff, input int exp_win,
                       input logic [7:0] exp_data);
    int win;
    int best;
    wait_issue(20);
    chk("age_eff", 64'(mux_priorities[loser*2 +: 2]), 64'(exp_eff));
    win  = -1;
    best = 4;
    for (int i = 0; i < 4; i++) begin
      if (mux_req[i] && (int'(mux_priorities[i*2 +: 2]) < best)) begin
        best = int'(mux_priorities[i*2 +: 2]);
        win  = i;
      end
    end
    if (win < 0) win = 0;
    mux_ack    = 4'(1 << win);
    mux_signal = mux_signals[win*8 +: 8];
    tick();
    mux_ack = 4'b0000;
    chk("round_win", 64'(out_index), 64'(exp_win));
    chk("round_data", 64'(out_data), 64'(exp_data));
    if (exp_win == 0) req_valid = 4'b0001;
    out_ready = 1'b1;
    tick();
    req_valid = 4'b0000;
    out_ready = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(req_ready), 64'h0F);
    chk({tag, "_mux_req"}, 64'(mux_req), 64'h0);
    chk({tag, "_mux_prio"}, 64'(mux_priorities), 64'hFF);
    chk({tag, "_mux_sig"}, 64'(mux_signals), 64'h0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'h0);
    chk({tag, "_out_data"}, 64'(out_data), 64'h0);
    chk({tag, "_out_index"}, 64'(out_index), 64'h0);
    chk({tag, "_err"}, 64'(err), 64'h0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

  logic [1:0] eff_ageing [7] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0};
  int         win_ageing [7] = '{0, 0, 0, 0, 0, 0, 1};
  logic [1:0] eff_sat    [9] = '{2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0};

  initial begin
    rst          = 1'b1;
    req_valid    = 4'b0000;
    req_priority = 8'h00;
    req_data     = 32'h0;
    mux_ack      = 4'b0000;
    mux_signal   = 8'h00;
    mux_busy     = 1'b0;
    out_ready    = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // single request on slot 2
    req_valid    = 4'b0100;
    req_priority = 8'h20;
    req_data     = 32'h00A5_0000;
    tick();
    req_valid = 4'b0000;
    chk("t1_ready_loaded", 64'(req_ready), 64'hB);
    chk("t1_no_issue_yet", 64'(mux_req), 64'h0);
    tick();
    chk("t1_mux_req", 64'(mux_req), 64'h4);
    chk("t1_mux_prio", 64'(mux_priorities[5:4]), 64'd2);
    chk("t1_mux_sig", 64'(mux_signals[23:16]), 64'hA5);
    mux_ack    = 4'b0100;
    mux_signal = 8'hA5;
    tick();
    mux_ack = 4'b0000;
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_out_data", 64'(out_data), 64'hA5);
    chk("t1_out_index", 64'(out_index), 64'd2);
    chk("t1_ready_back", 64'(req_ready), 64'hF);
    chk("t1_req_drop", 64'(mux_req), 64'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t1_accepted", 64'(out_valid), 64'd0);

    // priority order: slot 0 prio 3, slot 3 prio 1
    req_valid    = 4'b1001;
    req_priority = 8'h43;
    req_data     = 32'h3300_0011;
    tick();
    req_valid = 4'b0000;
    wait_issue(5);
    chk("t2_mux_req", 64'(mux_req), 64'h9);
    chk("t2_prio0", 64'(mux_priorities[1:0]), 64'd3);
    chk("t2_prio3", 64'(mux_priorities[7:6]), 64'd1);
    mux_ack    = 4'b1000;
    mux_signal = 8'h33;
    tick();
    mux_ack = 4'b0000;
    chk("t2_win_index", 64'(out_index), 64'd3);
    chk("t2_win_data", 64'(out_data), 64'h33);
    chk("t2_ready", 64'(req_ready), 64'hE);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_issue(5);
    chk("t2_second_req", 64'(mux_req), 64'h1);
    chk("t2_second_prio", 64'(mux_priorities[1:0]), 64'd3);
    mux_ack    = 4'b0001;
    mux_signal = 8'h11;
    tick();
    mux_ack = 4'b0000;
    chk("t2_second_index", 64'(out_index), 64'd0);
    chk("t2_second_data", 64'(out_data), 64'h11);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // ageing: slot 1 prio 3 against slot 0 prio 1, slot 0 reloaded on each win
    req_valid    = 4'b0011;
    req_priority = 8'h0D;
    req_data     = 32'h0000_4140;
    tick();
    req_valid = 4'b0000;
    for (int r = 0; r < 7; r++) begin
      round(1, eff_ageing[r], win_ageing[r], (win_ageing[r] == 0) ? 8'h40 : 8'h41);
    end

    // timeout: slot 0 still pending, never acknowledged
    wait_issue(5);
    chk("t4_issue", 64'(mux_req), 64'h1);
    repeat (15) tick();
    chk("t4_still_issue", 64'(mux_req), 64'h1);
    chk("t4_no_err_early", 64'(err), 64'd0);
    tick();
    chk("t4_err", 64'(err), 64'd1);
    chk("t4_req_drop", 64'(mux_req), 64'h0);
    chk("t4_slot_kept", 64'(req_ready), 64'hE);
    chk("t4_no_out", 64'(out_valid), 64'd0);
    tick();
    chk("t4_err_pulse", 64'(err), 64'd0);
    chk("t4_reissue", 64'(mux_req), 64'h1);

    // bad acks: out-of-mask, then not one-hot; load slot 1 during ISSUE
    req_valid    = 4'b0010;
    req_priority = 8'h09;
    req_data     = 32'h0000_5240;
    mux_ack      = 4'b1000;
    tick();
    req_valid = 4'b0000;
    mux_ack   = 4'b0000;
    chk("t5_err_mask", 64'(err), 64'd1);
    chk("t5_no_out", 64'(out_valid), 64'd0);
    chk("t5_ready", 64'(req_ready), 64'hC);
    tick();
    chk("t5_mask", 64'(mux_req), 64'h3);
    chk("t5_prio0_aged", 64'(mux_priorities[1:0]), 64'd1);
    chk("t5_prio1", 64'(mux_priorities[3:2]), 64'd2);
    mux_ack = 4'b0011;
    tick();
    mux_ack = 4'b0000;
    chk("t5_err_multi", 64'(err), 64'd1);
    chk("t5_no_out_multi", 64'(out_valid), 64'd0);
    tick();
    chk("t5_reissue", 64'(mux_req), 64'h3);
    chk("t5_ages_kept", 64'(mux_priorities[1:0]), 64'd1);
    mux_ack    = 4'b0001;
    mux_signal = 8'h40;
    tick();
    mux_ack = 4'b0000;
    chk("t5_good_valid", 64'(out_valid), 64'd1);
    chk("t5_good_index", 64'(out_index), 64'd0);
    chk("t5_good_data", 64'(out_data), 64'h40);
    chk("t5_ready_after", 64'(req_ready), 64'hD);

    // backpressure: slot 1 pending but no new ISSUE while output is held
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("t6_hold_valid", 64'(out_valid), 64'd1);
      chk("t6_hold_data", 64'(out_data), 64'h40);
      chk("t6_no_issue", 64'(mux_req), 64'h0);
    end
    rst = 1'b1;
    tick();
    chk_reset_outputs("t6_reset");
    rst = 1'b0;
    tick();

    // busy gating, then age saturation: slot 3 prio 3 loses to slot 0 prio 0
    mux_busy     = 1'b1;
    req_valid    = 4'b1001;
    req_priority = 8'hC0;
    req_data     = 32'h4F00_0040;
    tick();
    req_valid = 4'b0000;
    repeat (4) tick();
    chk("t7_busy_gate", 64'(mux_req), 64'h0);
    mux_busy = 1'b0;
    tick();
    chk("t7_issue_after_busy", 64'(mux_req), 64'h9);
    for (int r = 0; r < 9; r++) begin
      round(3, eff_sat[r], 0, 8'h40);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
